// File: rtl/host_matcher_pkg.sv
// host_matcher_pkg: shared host table widths and FSM state encoding
package host_matcher_pkg;
    localparam int HOST_ADDR_WIDTH  = 8;
    localparam int VALUE_DATA_WIDTH = 72;
    localparam int VALUE_SIZE       = 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] LAST = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/host_matcher.sv
// host_matcher: linear scan of a registered-read host table for the lowest entry equal to a key
module host_matcher
    import host_matcher_pkg::*;
#(
    parameter int ADDR_WIDTH = HOST_ADDR_WIDTH,
    parameter int DATA_WIDTH = VALUE_DATA_WIDTH + VALUE_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    input  logic [DATA_WIDTH-1:0] key_data,
    output logic                  key_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  match_valid,
    output logic                  match_hit,
    output logic [ADDR_WIDTH-1:0] match_index,
    input  logic                  match_ready
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] key_reg;
    logic                  eq;
    assign eq          = ram_q == key_reg;
    assign key_ready   = state == IDLE;
    assign match_valid = state == DONE;
    assign ram_addr    = state == SCAN ? cnt : '0;
    // ram_q lags the address by one cycle, so cnt==0 in SCAN marks the first cycle with nothing to compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_reg     <= '0;
            match_hit   <= 1'b0;
            match_index <= '0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    key_reg     <= key_data;
                    cnt         <= '0;
                    match_hit   <= 1'b0;
                    match_index <= '0;
                    state       <= SCAN;
                end
                SCAN: begin
                    cnt <= cnt + ONE;
                    if (cnt != '0 && eq) begin
                        match_hit   <= 1'b1;
                        match_index <= cnt - ONE;
                        state       <= DONE;
                    end else if (cnt == LAST_ADDR) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    match_hit   <= eq;
                    match_index <= eq ? LAST_ADDR : '0;
                    state       <= DONE;
                end
                default: if (match_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_matcher.sv
// tb_host_matcher: directed lookups against a 4-entry registered-read host table
module tb_host_matcher;
    localparam int AW = 2;
    localparam int DW = 80;
    localparam logic [DW-1:0] KEY_A = 80'h6f726465726d61746368;
    localparam logic [DW-1:0] KEY_B = 80'h63686f726465726d6174;
    localparam logic [DW-1:0] KEY_S = 80'h6f726465726d61746369;
    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          key_valid = 1'b0;
    logic [DW-1:0] key_data = '0;
    logic          key_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q = '0;
    logic          match_valid;
    logic          match_hit;
    logic [AW-1:0] match_index;
    logic          match_ready = 1'b0;
    logic [DW-1:0] mem [4];
    int vectors = 0;
    int miscompares = 0;

    host_matcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .ram_addr(ram_addr), .ram_q(ram_q),
        .match_valid(match_valid), .match_hit(match_hit), .match_index(match_index),
        .match_ready(match_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic lookup(input logic [DW-1:0] k, input logic eh, input logic [AW-1:0] ei,
                          input int lat, input int hold);
        int n;
        key_valid = 1'b1;
        key_data  = k;
        chk("key_ready_idle", 32'(key_ready), 1);
        tick();
        key_valid = 1'b0;
        n = 1;
        while (!match_valid && n < 20) begin
            if (lat == 6 && n <= 4) chk("scan_addr", 32'(ram_addr), 32'(n - 1));
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("hit", 32'(match_hit), 32'(eh));
        chk("index", 32'(match_index), 32'(ei));
        chk("done_addr", 32'(ram_addr), 0);
        repeat (hold) begin
            key_valid = 1'b1;
            key_data  = KEY_B;
            tick();
            chk("hold_valid", 32'(match_valid), 1);
            chk("hold_hit", 32'(match_hit), 32'(eh));
            chk("hold_index", 32'(match_index), 32'(ei));
            chk("hold_key_ready", 32'(key_ready), 0);
        end
        key_valid   = 1'b0;
        match_ready = 1'b1;
        tick();
        match_ready = 1'b0;
        chk("post_key_ready", 32'(key_ready), 1);
        chk("post_valid", 32'(match_valid), 0);
    endtask

    initial begin
        int n;
        mem[0] = KEY_A;
        mem[1] = KEY_B;
        mem[2] = KEY_A;
        mem[3] = KEY_A;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(match_valid), 0);
        chk("rst_key_ready", 32'(key_ready), 1);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_hit", 32'(match_hit), 0);
        chk("rst_index", 32'(match_index), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        lookup(KEY_A, 1'b1, 2'd0, 3, 0);
        lookup(KEY_B, 1'b1, 2'd1, 4, 0);
        lookup('0, 1'b0, 2'd0, 6, 0);
        lookup(KEY_S, 1'b0, 2'd0, 6, 0);
        lookup(KEY_B, 1'b1, 2'd1, 4, 5);
        // reset in the second SCAN cycle must drop the lookup silently
        key_valid = 1'b1;
        key_data  = '0;
        tick();
        key_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(ram_addr), 0);
        chk("mid_rst_valid", 32'(match_valid), 0);
        chk("mid_rst_hit", 32'(match_hit), 0);
        chk("mid_rst_index", 32'(match_index), 0);
        chk("mid_rst_key_ready", 32'(key_ready), 1);
        tick();
        reset_n = 1'b1;
        repeat (8) begin
            tick();
            chk("no_pulse_valid", 32'(match_valid), 0);
            chk("no_pulse_key_ready", 32'(key_ready), 1);
        end
        // back-to-back keys with match_ready tied high
        match_ready = 1'b1;
        key_valid   = 1'b1;
        key_data    = KEY_A;
        tick();
        key_data = KEY_B;
        n = 1;
        while (!match_valid && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 32'(n), 3);
        chk("b2b_hit1", 32'(match_hit), 1);
        chk("b2b_index1", 32'(match_index), 0);
        tick();
        chk("b2b_idle", 32'(key_ready), 1);
        tick();
        key_valid = 1'b0;
        chk("b2b_accepted", 32'(key_ready), 0);
        n = 1;
        while (!match_valid && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_lat2", 32'(n), 4);
        chk("b2b_hit2", 32'(match_hit), 1);
        chk("b2b_index2", 32'(match_index), 1);
        tick();
        match_ready = 1'b0;
        chk("b2b_end_valid", 32'(match_valid), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
